// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - washing-machine program sequencer (model select, stage timing, pause, done hold)
module wash_sequencer #(
    parameter int WASH_T    = 30,
    parameter int RINSE_T   = 20,
    parameter int DRY_T     = 10,
    parameter int DONE_HOLD = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_light,
    input  logic       sec_tick,
    input  logic       start_pulse,
    input  logic       model_pulse,
    output logic [2:0] current_model,
    output logic [1:0] current_program,
    output logic [1:0] run_state,
    output logic [6:0] remain_time,
    output logic       finish
);

    localparam int HW = (DONE_HOLD < 2) ? 1 : $clog2(DONE_HOLD + 1);

    localparam logic [1:0] P_WASH  = 2'b00;
    localparam logic [1:0] P_RINSE = 2'b01;
    localparam logic [1:0] P_DRY   = 2'b10;
    localparam logic [1:0] P_DONE  = 2'b11;

    localparam logic [6:0] T_WASH  = 7'(WASH_T);
    localparam logic [6:0] T_RINSE = 7'(RINSE_T);
    localparam logic [6:0] T_DRY   = 7'(DRY_T);
    localparam logic [6:0] T_ALL   = 7'(WASH_T + RINSE_T + DRY_T);
    localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    model_q, model_d;
    logic [1:0]    program_q, program_d;
    logic [6:0]    remain_q, remain_d;
    logic          finish_q, finish_d;
    logic [6:0]    stage_cnt_q, stage_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic [2:0]    model_next;
    logic [2:0]    next_info;

    // Unreachable codes 110/111 behave as model 000
    function automatic logic [2:0] norm_model(input logic [2:0] m);
        return (m > 3'd5) ? 3'd0 : m;
    endfunction

    function automatic logic [6:0] stage_time(input logic [1:0] p);
        case (p)
            P_WASH:  return T_WASH;
            P_RINSE: return T_RINSE;
            P_DRY:   return T_DRY;
            default: return 7'd0;
        endcase
    endfunction

    function automatic logic [1:0] first_stage(input logic [2:0] m);
        case (norm_model(m))
            3'd3, 3'd4: return P_RINSE;
            3'd5:       return P_DRY;
            default:    return P_WASH;
        endcase
    endfunction

    function automatic logic [6:0] model_total(input logic [2:0] m);
        case (norm_model(m))
            3'd1:    return T_WASH;
            3'd2:    return 7'(T_WASH + T_RINSE);
            3'd3:    return T_RINSE;
            3'd4:    return 7'(T_RINSE + T_DRY);
            3'd5:    return T_DRY;
            default: return T_ALL;
        endcase
    endfunction

    // {valid, stage} of the stage following p within model m
    function automatic logic [2:0] next_stage(input logic [2:0] m, input logic [1:0] p);
        logic [2:0] nm;
        nm = norm_model(m);
        if (p == P_WASH && (nm == 3'd0 || nm == 3'd2))
            return {1'b1, P_RINSE};
        else if (p == P_RINSE && (nm == 3'd0 || nm == 3'd4))
            return {1'b1, P_DRY};
        else
            return 3'b000;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || !power_light) begin
            state_q     <= S_IDLE;
            model_q     <= 3'd0;
            program_q   <= P_WASH;
            remain_q    <= T_ALL;
            finish_q    <= 1'b0;
            stage_cnt_q <= 7'd0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            model_q     <= model_d;
            program_q   <= program_d;
            remain_q    <= remain_d;
            finish_q    <= finish_d;
            stage_cnt_q <= stage_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        model_d     = model_q;
        program_d   = program_q;
        remain_d    = remain_q;
        finish_d    = finish_q;
        stage_cnt_d = stage_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        model_next  = (norm_model(model_q) == 3'd5) ? 3'd0 : norm_model(model_q) + 3'd1;
        next_info   = next_stage(model_q, program_q);

        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    state_d     = S_RUN;
                    model_d     = norm_model(model_q);
                    program_d   = first_stage(model_q);
                    remain_d    = model_total(model_q);
                    stage_cnt_d = stage_time(first_stage(model_q));
                end else if (model_pulse) begin
                    model_d   = model_next;
                    program_d = first_stage(model_next);
                    remain_d  = model_total(model_next);
                end
            end
            S_RUN: begin
                if (start_pulse) begin
                    state_d = S_PAUSE;
                end else if (sec_tick) begin
                    remain_d    = remain_q - 7'd1;
                    stage_cnt_d = stage_cnt_q - 7'd1;
                    if (stage_cnt_q == 7'd1) begin
                        if (next_info[2]) begin
                            program_d   = next_info[1:0];
                            stage_cnt_d = stage_time(next_info[1:0]);
                        end else begin
                            state_d     = S_DONE;
                            program_d   = P_DONE;
                            remain_d    = 7'd0;
                            finish_d    = 1'b1;
                            stage_cnt_d = 7'd0;
                            hold_cnt_d  = '0;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (start_pulse)
                    state_d = S_RUN;
            end
            S_DONE: begin
                if (sec_tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d     = S_IDLE;
                        model_d     = 3'd0;
                        program_d   = P_WASH;
                        remain_d    = T_ALL;
                        finish_d    = 1'b0;
                        stage_cnt_d = 7'd0;
                        hold_cnt_d  = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign current_model   = model_q;
    assign current_program = program_q;
    assign run_state       = state_q;
    assign remain_time     = remain_q;
    assign finish          = finish_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - scoreboard bench for wash_sequencer (W=3, R=2, D=1, hold=2)
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       power_light;
    logic       sec_tick;
    logic       start_pulse;
    logic       model_pulse;
    logic [2:0] current_model;
    logic [1:0] current_program;
    logic [1:0] run_state;
    logic [6:0] remain_time;
    logic       finish;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string tag;
        int    m;
        int    p;
        int    r;
        int    t;
        int    f;
    } exp_t;

    exp_t sb[$];

    wash_sequencer #(
        .WASH_T(3), .RINSE_T(2), .DRY_T(1), .DONE_HOLD(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .power_light(power_light),
        .sec_tick(sec_tick),
        .start_pulse(start_pulse),
        .model_pulse(model_pulse),
        .current_model(current_model),
        .current_program(current_program),
        .run_state(run_state),
        .remain_time(remain_time),
        .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of stimulus; the expected outputs after that edge go on the scoreboard
    task automatic step(input string tag, input logic r, input logic pw, input logic s,
                        input logic m, input logic t,
                        input int em, input int ep, input int er, input int et, input int ef);
        exp_t e;
        @(negedge clk);
        reset       = r;
        power_light = pw;
        start_pulse = s;
        model_pulse = m;
        sec_tick    = t;
        e = '{tag, em, ep, er, et, ef};
        sb.push_back(e);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        power_light = 1'b1;
        start_pulse = 1'b0;
        model_pulse = 1'b0;
        sec_tick    = 1'b0;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".model"},   int'(current_model),   e.m);
            check({e.tag, ".program"}, int'(current_program), e.p);
            check({e.tag, ".state"},   int'(run_state),       e.r);
            check({e.tag, ".remain"},  int'(remain_time),     e.t);
            check({e.tag, ".finish"},  int'(finish),          e.f);
        end
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1, 1, 0, 0, 0, 0, 0, 0, 6, 0);
    endtask

    int tab_m[6]   = '{1, 2, 3, 4, 5, 0};
    int tab_rem[6] = '{3, 5, 2, 3, 1, 6};
    int tab_p[6]   = '{0, 0, 1, 1, 2, 0};

    initial begin
        reset = 1'b1; power_light = 1'b1; sec_tick = 1'b0;
        start_pulse = 1'b0; model_pulse = 1'b0;

        do_reset("rst0");
        step("idle_tick", 0, 1, 0, 0, 1, 0, 0, 0, 6, 0);
        step("mp1", 0, 1, 0, 1, 0, 1, 0, 0, 3, 0);
        step("mp2", 0, 1, 0, 1, 0, 2, 0, 0, 5, 0);

        do_reset("rst1");
        step("start000", 0, 1, 1, 0, 0, 0, 0, 1, 6, 0);
        step("t1", 0, 1, 0, 0, 1, 0, 0, 1, 5, 0);
        step("t2", 0, 1, 0, 0, 1, 0, 0, 1, 4, 0);
        step("t3", 0, 1, 0, 0, 1, 0, 1, 1, 3, 0);
        step("t4", 0, 1, 0, 0, 1, 0, 1, 1, 2, 0);
        step("t5", 0, 1, 0, 0, 1, 0, 2, 1, 1, 0);
        step("t6", 0, 1, 0, 0, 1, 0, 3, 3, 0, 1);
        step("done_wait", 0, 1, 0, 0, 0, 0, 3, 3, 0, 1);
        step("hold1", 0, 1, 0, 0, 1, 0, 3, 3, 0, 1);
        step("hold2", 0, 1, 0, 0, 1, 0, 0, 0, 6, 0);

        step("p_start", 0, 1, 1, 0, 0, 0, 0, 1, 6, 0);
        step("p_t1", 0, 1, 0, 0, 1, 0, 0, 1, 5, 0);
        step("p_pause", 0, 1, 1, 0, 1, 0, 0, 2, 5, 0);
        for (int i = 0; i < 3; i++)
            step("p_frozen", 0, 1, 0, (i == 1), 1, 0, 0, 2, 5, 0);
        step("p_resume", 0, 1, 1, 0, 1, 0, 0, 1, 5, 0);
        step("p_t2", 0, 1, 0, 0, 1, 0, 0, 1, 4, 0);

        do_reset("rst2");
        for (int i = 0; i < 6; i++)
            step("wrap", 0, 1, 0, 1, 0, tab_m[i], tab_p[i], 0, tab_rem[i], 0);
        for (int i = 0; i < 5; i++)
            step("to101", 0, 1, 0, 1, 0, tab_m[i], tab_p[i], 0, tab_rem[i], 0);
        step("s101", 0, 1, 1, 0, 0, 5, 2, 1, 1, 0);
        step("t101", 0, 1, 0, 0, 1, 5, 3, 3, 0, 1);
        step("done_keys", 0, 1, 1, 1, 0, 5, 3, 3, 0, 1);
        step("h101a", 0, 1, 0, 0, 1, 5, 3, 3, 0, 1);
        step("h101b", 0, 1, 0, 0, 1, 0, 0, 0, 6, 0);

        for (int i = 0; i < 4; i++)
            step("to100", 0, 1, 0, 1, 0, tab_m[i], tab_p[i], 0, tab_rem[i], 0);
        step("s100", 0, 1, 1, 0, 0, 4, 1, 1, 3, 0);
        step("t100", 0, 1, 0, 0, 1, 4, 1, 1, 2, 0);
        step("pwr_off", 0, 0, 0, 0, 1, 0, 0, 0, 6, 0);
        step("pwr_off_key", 0, 0, 1, 1, 0, 0, 0, 0, 6, 0);
        step("rst_over_pwr", 1, 1, 1, 1, 1, 0, 0, 0, 6, 0);

        step("m001", 0, 1, 0, 1, 0, 1, 0, 0, 3, 0);
        step("start_and_model", 0, 1, 1, 1, 0, 1, 0, 1, 3, 0);
        step("run_model_ign", 0, 1, 0, 1, 1, 1, 0, 1, 2, 0);
        step("w_t2", 0, 1, 0, 0, 1, 1, 0, 1, 1, 0);
        step("w_t3_done", 0, 1, 0, 0, 1, 1, 3, 3, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
